bn_ctrl: RTL and testbench

BN_CTRL -- requirements
Module: bn_ctrl

---
 rtl/bn_pkg.sv | 24 ++
 rtl/bn_valid_pipe.sv | 36 +++
 rtl/bn_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bn_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared types and constants for the batch-norm controller: FSM state encoding,
// fp16 word width and the gamma/beta field positions inside a parameter word.
package bn_pkg;

  localparam int FP16_W = 16;

  // Field index inside param_rd_data, in units of one data word.
  localparam int BETA_FIELD  = 0;
  localparam int GAMMA_FIELD = 1;

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_preq   = 3'd1,
    st_pwait  = 3'd2,
    st_stream = 3'd3,
    st_drain  = 3'd4,
    st_done   = 3'd5
  } bn_state_e;

  function automatic int field_lsb(input int field, input int width);
    return field * width;
  endfunction

endpackage

// File: rtl/bn_valid_pipe.sv
// Fixed-latency valid/last shift register that mirrors the bn datapath depth,
// with an empty flag used to decide when the job has fully drained.
module bn_valid_pipe #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last,
  output logic empty
);

  logic [LAT-1:0] vld_sr;
  logic [LAT-1:0] last_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= in_valid;
      last_sr[0] <= in_valid && in_last;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[LAT-1];
  assign out_last  = last_sr[LAT-1];
  assign empty     = (vld_sr == '0);

endmodule

// File: rtl/bn_ctrl.sv
// Batch-norm job controller: fetches per-channel gamma/beta, streams vectors into
// the bn datapath under downstream credit control. BN_CTRL_PERF_EN adds perf counters.
module bn_ctrl
  import bn_pkg::*;
#(
  parameter int DATA_WIDTH = FP16_W,
  parameter int SIZE       = 8,
  parameter int BN_LAT     = 4,
  parameter int CH_W       = 10,
  parameter int WPC_W      = 12,
  parameter int CREDITS    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CH_W-1:0]            num_ch,
  input  logic [WPC_W-1:0]           words_per_ch,
  output logic                       busy,
  output logic                       done,
  output logic                       param_rd_en,
  output logic [CH_W-1:0]            param_rd_addr,
  input  logic [2*DATA_WIDTH-1:0]    param_rd_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*SIZE-1:0] in_data,
  output logic [DATA_WIDTH*SIZE-1:0] bn_x,
  output logic [DATA_WIDTH-1:0]      bn_gamma,
  output logic [DATA_WIDTH-1:0]      bn_beta,
  output logic                       bn_valid,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       credit_ret,
  output logic [2:0]                 state_dbg
`ifdef BN_CTRL_PERF_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_stalls
`endif
);

  localparam int CRW       = $clog2(CREDITS + 1);
  localparam int GAMMA_LSB = field_lsb(GAMMA_FIELD, DATA_WIDTH);
  localparam int BETA_LSB  = field_lsb(BETA_FIELD, DATA_WIDTH);

  bn_state_e         state;
  bn_state_e         state_nxt;
  logic [CH_W-1:0]   num_ch_q;
  logic [CH_W-1:0]   ch;
  logic [WPC_W-1:0]  wpc_q;
  logic [WPC_W-1:0]  word;
  logic [CRW-1:0]    credits;
  logic              xfer;
  logic              ch_end;
  logic              job_end;
  logic              pipe_empty;

  // in_valid/in_ready: a vector moves on any cycle where both are high; in_ready
  // is only raised in STREAM while at least one downstream credit is available.
  assign in_ready = (state == st_stream) && (credits != '0);
  assign xfer     = in_valid && in_ready;
  assign bn_valid = xfer;
  assign bn_x     = xfer ? in_data : '0;

  assign ch_end  = xfer && (word == wpc_q - WPC_W'(1));
  assign job_end = ch_end && (ch == num_ch_q - CH_W'(1));

  assign busy          = (state != st_idle);
  assign done          = (state == st_done);
  assign param_rd_en   = (state == st_preq);
  assign param_rd_addr = ch;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) state <= st_idle;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: begin
        if (start) begin
          if (num_ch == '0 || words_per_ch == '0) state_nxt = st_done;
          else                                    state_nxt = st_preq;
        end
      end
      st_preq:  state_nxt = st_pwait;
      st_pwait: state_nxt = st_stream;
      st_stream: begin
        if (job_end)     state_nxt = st_drain;
        else if (ch_end) state_nxt = st_preq;
      end
      st_drain: if (pipe_empty) state_nxt = st_done;
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  // Job bookkeeping; gamma/beta are captured once per channel and then held.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_ch_q <= '0;
      wpc_q    <= '0;
      ch       <= '0;
      word     <= '0;
      bn_gamma <= '0;
      bn_beta  <= '0;
    end else begin
      if (state == st_idle && start) begin
        num_ch_q <= num_ch;
        wpc_q    <= words_per_ch;
        ch       <= '0;
      end
      if (state == st_pwait) begin
        bn_gamma <= param_rd_data[GAMMA_LSB +: DATA_WIDTH];
        bn_beta  <= param_rd_data[BETA_LSB +: DATA_WIDTH];
        word     <= '0;
      end
      if (ch_end) begin
        if (!job_end) ch <= ch + CH_W'(1);
      end else if (xfer) begin
        word <= word + WPC_W'(1);
      end
    end
  end

  // A simultaneous issue and return cancel out; returns beyond CREDITS are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= CRW'(CREDITS);
    end else if (xfer && !credit_ret) begin
      credits <= credits - CRW'(1);
    end else if (credit_ret && !xfer && credits != CRW'(CREDITS)) begin
      credits <= credits + CRW'(1);
    end
  end

  bn_valid_pipe #(
    .LAT (BN_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (xfer),
    .in_last   (job_end),
    .out_valid (out_valid),
    .out_last  (out_last),
    .empty     (pipe_empty)
  );

`ifdef BN_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || (state == st_idle && start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 32'd1;
      if (state == st_stream && in_valid && !in_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bn_ctrl.sv
// Randomized scoreboard bench for bn_ctrl: expected issue/output streams are
// built per job from the channel parameters and the parameter memory contents.
module tb_bn_ctrl;

  localparam int DW   = 16;
  localparam int SZ   = 8;
  localparam int LAT  = 4;
  localparam int CHW  = 10;
  localparam int WPCW = 12;
  localparam int CRED = 8;
  localparam int VW   = DW * SZ;
  localparam int EW   = VW + 2 * DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            start = 1'b0;
  logic [CHW-1:0]  num_ch = '0;
  logic [WPCW-1:0] words_per_ch = '0;
  logic            busy, done, param_rd_en;
  logic [CHW-1:0]  param_rd_addr;
  logic [2*DW-1:0] param_rd_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [VW-1:0]   in_data = '0;
  logic [VW-1:0]   bn_x;
  logic [DW-1:0]   bn_gamma, bn_beta;
  logic            bn_valid, out_valid, out_last;
  logic            credit_ret = 1'b0;
  logic [2:0]      state_dbg;

  bn_ctrl #(
    .DATA_WIDTH (DW), .SIZE (SZ), .BN_LAT (LAT),
    .CH_W (CHW), .WPC_W (WPCW), .CREDITS (CRED)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .num_ch (num_ch),
    .words_per_ch (words_per_ch), .busy (busy), .done (done),
    .param_rd_en (param_rd_en), .param_rd_addr (param_rd_addr),
    .param_rd_data (param_rd_data), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .bn_x (bn_x), .bn_gamma (bn_gamma), .bn_beta (bn_beta),
    .bn_valid (bn_valid), .out_valid (out_valid), .out_last (out_last),
    .credit_ret (credit_ret), .state_dbg (state_dbg)
  );

  // Parameter memory: {gamma, beta}, read data one cycle after the strobe.
  logic [2*DW-1:0] pmem [0:(1<<CHW)-1];
  always @(posedge clk) if (param_rd_en) param_rd_data <= pmem[param_rd_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];      // {last, gamma, beta, x} per expected issue
  int            lat_cyc_q[$];  // cycle when the matching out_valid is due
  bit            lat_last_q[$];
  int            par_q[$];      // expected parameter read addresses
  logic [VW-1:0] vecs[$];
  int xfer_tot = 0, xfer_base = 0;
  int job_nvec = 0, job_nc = 0, job_wpc = 0, start_cyc = 0, dbl_at = 0;
  int done_cnt = 0, done_base = 0, done_cyc = 0, last_out_cyc = 0, last_issue_cyc = 0;
  int cred = CRED;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            due;
    bit            lst;
    int            p;
    if (reset) begin
      cred = CRED;
      exp_q.delete();
      lat_cyc_q.delete();
      lat_last_q.delete();
      par_q.delete();
    end else if (mon_en) begin
      chk("bn_valid_xfer", bn_valid, in_valid && in_ready);
      if (!busy) chk("in_ready_idle", in_ready, 0);
      if (cred == 0) chk("in_ready_nocredit", in_ready, 0);
      if (bn_valid) begin
        if (exp_q.size() == 0) chk("spurious_bn_valid", bn_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("bn_x", bn_x, e[VW-1:0]);
          chk("bn_beta", bn_beta, e[VW+DW-1:VW]);
          chk("bn_gamma", bn_gamma, e[VW+2*DW-1:VW+DW]);
          lat_cyc_q.push_back(cyc + LAT);
          lat_last_q.push_back(e[EW-1]);
          last_issue_cyc = cyc;
        end
      end
      if (out_valid) begin
        if (lat_cyc_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
        else begin
          due = lat_cyc_q.pop_front();
          lst = lat_last_q.pop_front();
          chk("out_latency", cyc, due);
          chk("out_last", out_last, lst);
          last_out_cyc = cyc;
        end
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      if (param_rd_en) begin
        if (par_q.size() == 0) chk("spurious_param_rd", param_rd_en, 0);
        else begin
          p = par_q.pop_front();
          chk("param_rd_addr", param_rd_addr, p);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_valid && in_ready) xfer_tot++;
      cred = cred - ((in_valid && in_ready) ? 1 : 0) + (credit_ret ? 1 : 0);
      if (cred > CRED) cred = CRED;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_job(input int nc, input int wpc);
    logic [VW-1:0] v;
    int nvec;
    nvec = nc * wpc;
    vecs.delete();
    for (int k = 0; k < nvec; k++) begin
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs.push_back(v);
      exp_q.push_back({(k == nvec - 1), pmem[k / wpc], v});
    end
    if (nvec > 0) for (int c = 0; c < nc; c++) par_q.push_back(c);
    job_nvec = nvec; job_nc = nc; job_wpc = wpc;
    xfer_base = xfer_tot;
    done_base = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; num_ch = CHW'(nc); words_per_ch = WPCW'(wpc);
    in_valid = 1'b0; credit_ret = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic drive_cycle(input int vld_pct, input int ret_pct);
    int idx;
    @(posedge clk); #1;
    if (dbl_at > 0 && cyc == start_cyc + dbl_at) begin
      start = 1'b1; num_ch = CHW'(3); words_per_ch = WPCW'(5);
    end else begin
      start = 1'b0;
    end
    idx = xfer_tot - xfer_base;
    if (idx < job_nvec && $urandom_range(99) < vld_pct) begin
      in_valid = 1'b1;
      in_data  = vecs[idx];
    end else begin
      in_valid = 1'b0;
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    credit_ret = ($urandom_range(99) < ret_pct);
  endtask

  task automatic end_job(input int vld_pct, input int ret_pct, input bit full_rate);
    int t = 0;
    while (done_cnt == done_base && t < 3000) begin
      drive_cycle(vld_pct, ret_pct);
      t++;
    end
    repeat (8) drive_cycle(0, ret_pct);
    chk("done_count", done_cnt - done_base, 1);
    chk("issued_all", xfer_tot - xfer_base, job_nvec);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("out_q_drained", lat_cyc_q.size(), 0);
    chk("param_q_drained", par_q.size(), 0);
    if (job_nvec > 0) chk("done_after_drain", (done_cyc - last_out_cyc >= 1) && (done_cyc - last_out_cyc <= 3), 1);
    else              chk("zero_job_done", done_cyc, start_cyc + 1);
    if (full_rate && job_nvec > 0) chk("job_throughput", last_issue_cyc - start_cyc, job_nc * (job_wpc + 2));
    exp_q.delete(); lat_cyc_q.delete(); lat_last_q.delete(); par_q.delete();
  endtask

  task automatic abort_then_credit_test();
    int t = 0;
    begin_job(1, 6);
    while (xfer_tot - xfer_base < 2 && t < 100) begin
      drive_cycle(100, 100);
      t++;
    end
    chk("abort_reached", xfer_tot - xfer_base, 2);
    reset = 1'b1; in_valid = 1'b0; credit_ret = 1'b0; start = 1'b0;
    done_base = done_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
    end
    chk("abort_no_done", done_cnt - done_base, 0);
    // Credits are back at CREDITS: with no returns exactly that many vectors move.
    begin_job(1, 20);
    repeat (30) drive_cycle(100, 0);
    chk("credit_stall_count", xfer_tot - xfer_base, CRED);
    @(negedge clk);
    chk("credit_stall_ready", in_ready, 0);
    drive_cycle(100, 100);
    repeat (10) drive_cycle(100, 0);
    chk("credit_one_more", xfer_tot - xfer_base, CRED + 1);
    end_job(100, 100, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1 << CHW); i++) pmem[i] = {$urandom()};
    pmem[0] = {16'h3C00, 16'h0000};
    pmem[1] = {16'h3400, 16'h3C00};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bn_valid", bn_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_param_rd_en", param_rd_en, 0);
    chk("rst_param_rd_addr", param_rd_addr, 0);
    chk("rst_bn_x", bn_x, 0);
    chk("rst_bn_gamma", bn_gamma, 0);
    chk("rst_bn_beta", bn_beta, 0);
    mon_en = 1'b1;

    // Two channels of three vectors at full rate with known gamma/beta.
    begin_job(2, 3);
    end_job(100, 100, 1'b1);

    // Empty jobs complete without touching memory or the datapath.
    begin_job(0, 5);
    end_job(100, 100, 1'b0);
    begin_job(3, 0);
    end_job(100, 100, 1'b0);

    for (int j = 0; j < 6; j++) begin
      begin_job($urandom_range(1, 4), $urandom_range(1, 6));
      end_job(70, 60, 1'b0);
    end

    // A second start while busy must not disturb the running job.
    dbl_at = 3;
    begin_job(2, 4);
    end_job(100, 100, 1'b1);
    dbl_at = 0;

    abort_then_credit_test();

    begin_job(3, 5);
    end_job(100, 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
